// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default cycle counts
// and frame helpers, intended for reuse by the receive side as well.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_START,
      ST_SEND,
      ST_ACK,
      ST_RELEASE,
      ST_DONE,
      ST_ERROR
   } ps2_state_t;

   // 100 us clock inhibit and 15 ms device timeout at 50 MHz
   localparam int PS2_INHIBIT_CYCLES = 5000;
   localparam int PS2_TIMEOUT_CYCLES = 750000;

   // falls that clock out d0..d7, parity and stop
   localparam int PS2_FRAME_BITS = 10;

   function automatic logic ps2_odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins, plus a registered
// falling-edge strobe on the synchronized clock.
module ps2_line_sync (
   input  logic clock,
   input  logic resetn,
   input  logic ps2_clock_in,
   input  logic ps2_data_in,
   output logic clock_s,
   output logic data_s,
   output logic fall
);

   logic [1:0] r_clk_sync;
   logic [1:0] r_dat_sync;
   logic       r_clk_prev;
   logic       r_fall;

   // idle bus is high; resetting to 1 avoids a false edge after reset
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
         r_clk_prev <= 1'b1;
         r_fall     <= 1'b0;
      end else begin
         r_clk_sync <= {r_clk_sync[0], ps2_clock_in};
         r_dat_sync <= {r_dat_sync[0], ps2_data_in};
         r_clk_prev <= r_clk_sync[1];
         r_fall     <= r_clk_prev & ~r_clk_sync[1];
      end
   end

   assign clock_s = r_clk_sync[1];
   assign data_s  = r_dat_sync[1];
   assign fall    = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, start bit, 8 data bits LSB
// first, odd parity, stop, then device ACK check, over open-drain enables.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       send_command,
   input  logic [7:0] command_data,
   input  logic       ps2_clock_in,
   input  logic       ps2_data_in,
   output logic       ps2_clock_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       command_sent,
   output logic       error_timeout,
   output logic       error_no_ack
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic w_clock_s;
   logic w_data_s;
   logic w_fall;

   ps2_line_sync u_sync (
      .clock        (clock),
      .resetn       (resetn),
      .ps2_clock_in (ps2_clock_in),
      .ps2_data_in  (ps2_data_in),
      .clock_s      (w_clock_s),
      .data_s       (w_data_s),
      .fall         (w_fall)
   );

   ps2_state_t    r_state;
   ps2_state_t    w_state_nxt;
   logic [9:0]    r_shift;
   logic          r_cur_bit;
   logic [3:0]    r_bit_cnt;
   logic [IW-1:0] r_inh_cnt;
   logic [TW-1:0] r_to_cnt;
   logic          r_err_to;

   logic w_load;
   logic w_shift;
   logic w_to_abort;
   logic w_to_hit;
   logic w_waiting;

   assign w_to_hit  = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign w_waiting = (r_state == ST_SEND) || (r_state == ST_ACK) ||
                      (r_state == ST_RELEASE);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_to_abort  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (send_command) begin
               w_load      = 1'b1;
               w_state_nxt = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (r_inh_cnt == IW'(INHIBIT_CYCLES - 1)) w_state_nxt = ST_START;
         end
         ST_START: w_state_nxt = ST_SEND;
         ST_SEND: begin
            if (w_fall) begin
               w_shift = 1'b1;
               if (r_bit_cnt == 4'(PS2_FRAME_BITS - 1)) w_state_nxt = ST_ACK;
            end else if (w_to_hit) begin
               w_to_abort  = 1'b1;
               w_state_nxt = ST_ERROR;
            end
         end
         ST_ACK: begin
            if (w_fall) begin
               w_state_nxt = w_data_s ? ST_ERROR : ST_RELEASE;
            end else if (w_to_hit) begin
               w_to_abort  = 1'b1;
               w_state_nxt = ST_ERROR;
            end
         end
         ST_RELEASE: begin
            if (w_clock_s && w_data_s) begin
               w_state_nxt = ST_DONE;
            end else if (w_to_hit) begin
               w_to_abort  = 1'b1;
               w_state_nxt = ST_ERROR;
            end
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         ST_ERROR: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // frame shifter: r_cur_bit is the bit currently on the data line
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_shift   <= '1;
         r_cur_bit <= 1'b1;
         r_bit_cnt <= '0;
      end else if (w_load) begin
         r_shift   <= {1'b1, ps2_odd_parity(command_data), command_data};
         r_cur_bit <= 1'b0;
         r_bit_cnt <= '0;
      end else if (w_shift) begin
         r_shift   <= {1'b1, r_shift[9:1]};
         r_cur_bit <= r_shift[0];
         r_bit_cnt <= r_bit_cnt + 4'd1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                     r_inh_cnt <= '0;
      else if (r_state == ST_INHIBIT)  r_inh_cnt <= r_inh_cnt + IW'(1);
      else                             r_inh_cnt <= '0;
   end

   // holds cycles elapsed since the last fall (or SEND entry), that cycle counted as 1
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                            r_to_cnt <= '0;
      else if (w_fall || r_state == ST_START) r_to_cnt <= TW'(1);
      else if (w_waiting && !w_to_hit)        r_to_cnt <= r_to_cnt + TW'(1);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                  r_err_to <= 1'b0;
      else if (w_to_abort)          r_err_to <= 1'b1;
      else if (r_state == ST_IDLE)  r_err_to <= 1'b0;
   end

   assign ps2_clock_oe  = (r_state == ST_INHIBIT) || (r_state == ST_START);
   assign ps2_data_oe   = ((r_state == ST_START) || (r_state == ST_SEND)) && !r_cur_bit;
   assign busy          = (r_state != ST_IDLE);
   assign command_sent  = (r_state == ST_DONE);
   assign error_timeout = (r_state == ST_ERROR) && r_err_to;
   assign error_no_ack  = (r_state == ST_ERROR) && !r_err_to;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a device model that clocks the
// frame in, ACKs, withholds ACK or stalls, checked against a frame model.
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int TO   = 300;
   localparam int HALF = 12;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       send_command = 1'b0;
   logic [7:0] command_data = 8'h00;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       ps2_clock_in, ps2_data_in;
   logic       ps2_clock_oe, ps2_data_oe, busy;
   logic       command_sent, error_timeout, error_no_ack;

   assign ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
   assign ps2_data_in  = ~(ps2_data_oe | dev_dat_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .send_command  (send_command),
      .command_data  (command_data),
      .ps2_clock_in  (ps2_clock_in),
      .ps2_data_in   (ps2_data_in),
      .ps2_clock_oe  (ps2_clock_oe),
      .ps2_data_oe   (ps2_data_oe),
      .busy          (busy),
      .command_sent  (command_sent),
      .error_timeout (error_timeout),
      .error_no_ack  (error_no_ack)
   );

   always #10 clock = ~clock;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, last_fall = 0;
   int mon_sent = 0, mon_noack = 0, mon_to = 0, mon_to_cyc = 0, excl_viol = 0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (command_sent)  mon_sent  <= mon_sent + 1;
      if (error_no_ack)  mon_noack <= mon_noack + 1;
      if (error_timeout) begin
         mon_to     <= mon_to + 1;
         mon_to_cyc <= cyc;
      end
      if (int'(command_sent) + int'(error_timeout) + int'(error_no_ack) > 1)
         excl_viol <= excl_viol + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // {stop, parity, d7..d0, start} as the device should see it on the wire
   function automatic logic [10:0] frame(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
   endfunction

   task automatic dev_pulse(output logic smp);
      @(negedge clock);
      dev_clk_low = 1'b1;
      last_fall   = cyc;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clock);
      smp = ps2_data_in;
   endtask

   task automatic run_txn(input logic [7:0] cmd, input bit ack, input int nbits,
                          input int repulse_at, input int rst_at,
                          output logic [10:0] rx, output int inh_len,
                          output int n_sent, output int n_noack, output int n_to,
                          output int to_lat);
      logic smp;
      int   t, ovl, s0, a0, e0;
      rx = '1; inh_len = 0; ovl = 0;
      s0 = mon_sent; a0 = mon_noack; e0 = mon_to;
      n_sent = 0; n_noack = 0; n_to = 0; to_lat = -1;
      @(negedge clock);
      send_command = 1'b1;
      command_data = cmd;
      @(negedge clock);
      send_command = 1'b0;
      command_data = 8'($urandom);
      chk("busy_after_accept", busy, 1);
      chk("clk_oe_after_accept", ps2_clock_oe, 1);
      t = 0;
      while (ps2_clock_oe && t < INH + 50) begin
         inh_len++;
         if (ps2_data_oe) ovl++;
         @(negedge clock);
         t++;
      end
      chk("start_overlap", ovl, 1);
      repeat (HALF) @(negedge clock);
      rx[0] = ps2_data_in;
      for (int k = 0; k < nbits; k++) begin
         if (k == repulse_at) begin
            send_command = 1'b1;
            command_data = 8'h00;
            @(negedge clock);
            send_command = 1'b0;
         end
         if (k == rst_at) begin
            chk("pre_reset_data_oe", ps2_data_oe, !cmd[k-1]);
            resetn = 1'b0;
            #1;
            chk("reset_clk_oe", ps2_clock_oe, 0);
            chk("reset_data_oe", ps2_data_oe, 0);
            chk("reset_busy", busy, 0);
            return;
         end
         dev_pulse(smp);
         rx[k+1] = smp;
      end
      if (nbits == 10) begin
         @(negedge clock);
         dev_dat_low = ack;
         repeat (HALF) @(negedge clock);
         dev_pulse(smp);
         dev_dat_low = 1'b0;
      end
      t = 0;
      while (busy && t < TO + 100) begin
         @(negedge clock);
         t++;
      end
      if (busy) chk("busy_wait_bound", busy, 0);
      @(negedge clock);
      n_sent  = mon_sent - s0;
      n_noack = mon_noack - a0;
      n_to    = mon_to - e0;
      to_lat  = mon_to_cyc - last_fall;
   endtask

   task automatic do_vec(input logic [7:0] cmd, input bit ack, input int nbits,
                         input int repulse_at, input bit es, input bit en, input bit et);
      logic [10:0] rx, mask;
      int inh_len, ns, na, nt, lat;
      run_txn(cmd, ack, nbits, repulse_at, -1, rx, inh_len, ns, na, nt, lat);
      mask = (nbits >= 10) ? 11'h7FF : 11'((32'd1 << (nbits + 1)) - 1);
      chk("frame_bits", rx & mask, frame(cmd) & mask);
      chk("inhibit_len", inh_len, INH + 1);
      chk("sent_pulses", ns, es);
      chk("noack_pulses", na, en);
      chk("timeout_pulses", nt, et);
      if (et) chk("timeout_latency", lat, TO + 3);
      chk("idle_lines", {ps2_clock_oe, ps2_data_oe, busy}, 0);
   endtask

   typedef struct {
      logic [7:0] cmd;
      bit         ack;
      int         nbits;
      bit         es;
      bit         en;
      bit         et;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [10:0] rx;
      int inh_len, ns, na, nt, lat;

      tbl[0] = '{8'hED, 1'b1, 10, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{8'hF4, 1'b1, 10, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{8'hFF, 1'b0, 10, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{8'hA5, 1'b1,  4, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{8'h00, 1'b1, 10, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{8'h80, 1'b0, 10, 1'b0, 1'b1, 1'b0};

      repeat (3) @(negedge clock);
      chk("reset_outputs", {ps2_clock_oe, ps2_data_oe, busy, command_sent,
                            error_timeout, error_no_ack}, 0);
      resetn = 1'b1;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 6; i++)
         do_vec(tbl[i].cmd, tbl[i].ack, tbl[i].nbits, -1, tbl[i].es, tbl[i].en, tbl[i].et);

      // request while busy must not disturb the byte in flight
      do_vec(8'hED, 1'b1, 10, 3, 1'b1, 1'b0, 1'b0);

      // reset while d5 (a 0) is on the line, then a clean transfer
      run_txn(8'h1B, 1'b1, 10, -1, 6, rx, inh_len, ns, na, nt, lat);
      repeat (4) @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      chk("post_reset_idle", {ps2_clock_oe, ps2_data_oe, busy}, 0);
      do_vec(8'hF4, 1'b1, 10, -1, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         logic [7:0] c;
         bit         a;
         int         nb;
         c  = 8'($urandom);
         a  = 1'($urandom_range(0, 1));
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 10;
         do_vec(c, a, nb, -1, (nb == 10) && a, (nb == 10) && !a, nb < 10);
      end

      chk("flag_exclusive", excl_viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
